// File: rtl/sync_fifo_pkg.sv
// Shared helpers for sync_fifo: word parity and the legal flag-threshold ranges.
// The optional parity protection is enabled by defining SYNC_FIFO_PARITY_EN.
package sync_fifo_pkg;

  localparam int MAX_DATASIZE = 64;
  localparam int AE_THR_HEADROOM = 1;

  // Returns the bit that makes the total number of ones even.
  function automatic logic parity_even(input logic [MAX_DATASIZE-1:0] d);
    return ^d;
  endfunction

  function automatic bit config_ok(input int datasize, input int depth,
                                   input int af_thr, input int ae_thr);
    return (datasize >= 1) && (datasize <= MAX_DATASIZE) &&
           (af_thr >= 0) && (af_thr <= depth) &&
           (ae_thr >= 0) && (ae_thr <= depth - AE_THR_HEADROOM);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a producer/consumer and sync_fifo.
// The producer/consumer side uses the master modport and the FIFO uses the slave modport.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic [DATASIZE-1:0] wdata;
  logic                rinc;
  logic [DATASIZE-1:0] rdata;
  logic                wfull;
  logic                awfull;
  logic                rempty;
  logic                arempty;
  logic [ADDRSIZE:0]   level;
  logic                ovf;
  logic                udf;
  logic                perr;

  modport master (
    output winc, wdata, rinc,
    input  rdata, wfull, awfull, rempty, arempty, level, ovf, udf, perr
  );

  modport slave (
    input  winc, wdata, rinc,
    output rdata, wfull, awfull, rempty, arempty, level, ovf, udf, perr
  );
endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo: one write port plus one read port that is either
// combinational (FALLTHROUGH="TRUE") or registered on read enable (FALLTHROUGH="FALSE").
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int    WIDTH       = 8,
  parameter int    ADDRSIZE    = 4,
  parameter string FALLTHROUGH = "TRUE"
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                we_i,
  input  logic [ADDRSIZE-1:0] waddr_i,
  input  logic [WIDTH-1:0]    wdata_i,
  input  logic                re_i,
  input  logic [ADDRSIZE-1:0] raddr_i,
  output logic [WIDTH-1:0]    rdata_o
);
  localparam int DEPTH = 1 << ADDRSIZE;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  if (FALLTHROUGH == "FALSE") begin : g_reg
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
        rdata_q <= '0;
      end else if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end
    end

    assign rdata_o = rdata_q;
  end else begin : g_fwft
    logic unused_s;
    assign unused_s = &{1'b0, re_i, arst};
    assign rdata_o  = mem_q[raddr_i];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level, almost-full/empty flags and overflow/underflow pulses.
// Defining SYNC_FIFO_PARITY_EN widens storage by one even-parity bit and drives perr.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int    DATASIZE         = 8,
  parameter int    ADDRSIZE         = 4,
  parameter string FALLTHROUGH      = "TRUE",
  parameter int    ALMOST_FULL_THR  = (1 << ADDRSIZE) - 1,
  parameter int    ALMOST_EMPTY_THR = 1
) (
  input  logic        clk,
  input  logic        arst,
  sync_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam int PW    = ADDRSIZE + 1;
`ifdef SYNC_FIFO_PARITY_EN
  localparam int MW    = DATASIZE + 1;
`else
  localparam int MW    = DATASIZE;
`endif
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] LVL_FULL = PW'(DEPTH);
  localparam logic [PW-1:0] LVL_ZERO = PW'(0);
  localparam logic [PW-1:0] LVL_AF   = PW'(ALMOST_FULL_THR);
  localparam logic [PW-1:0] LVL_AE   = PW'(ALMOST_EMPTY_THR);

  if (!config_ok(DATASIZE, DEPTH, ALMOST_FULL_THR, ALMOST_EMPTY_THR)) begin : g_bad_cfg
    $error("sync_fifo: DATASIZE or almost-full/almost-empty threshold out of range");
  end

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic          wfull_q, awfull_q, rempty_q, arempty_q, ovf_q, udf_q;
  logic          wr_en_s, rd_en_s;
  logic [MW-1:0] wword_s, rword_s;

  assign wr_en_s = bus.winc & ~wfull_q;
  assign rd_en_s = bus.rinc & ~rempty_q;

  // Pointers wrap modulo 2*DEPTH, so their difference is the exact occupancy.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_en_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    level_d = wptr_d - rptr_d;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      wfull_q   <= 1'b0;
      awfull_q  <= 1'b0;
      rempty_q  <= 1'b1;
      arempty_q <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      wfull_q   <= (level_d == LVL_FULL);
      awfull_q  <= (level_d >= LVL_AF);
      rempty_q  <= (level_d == LVL_ZERO);
      arempty_q <= (level_d <= LVL_AE);
      ovf_q     <= bus.winc & wfull_q;
      udf_q     <= bus.rinc & rempty_q;
    end
  end

`ifdef SYNC_FIFO_PARITY_EN
  assign wword_s = {parity_even(MAX_DATASIZE'(bus.wdata)), bus.wdata};
`else
  assign wword_s = bus.wdata;
`endif

  sync_fifo_ram #(
    .WIDTH       (MW),
    .ADDRSIZE    (ADDRSIZE),
    .FALLTHROUGH (FALLTHROUGH)
  ) u_ram (
    .clk     (clk),
    .arst    (arst),
    .we_i    (wr_en_s),
    .waddr_i (wptr_q[ADDRSIZE-1:0]),
    .wdata_i (wword_s),
    .re_i    (rd_en_s),
    .raddr_i (rptr_q[ADDRSIZE-1:0]),
    .rdata_o (rword_s)
  );

  assign bus.rdata   = rword_s[DATASIZE-1:0];
  assign bus.level   = level_q;
  assign bus.wfull   = wfull_q;
  assign bus.awfull  = awfull_q;
  assign bus.rempty  = rempty_q;
  assign bus.arempty = arempty_q;
  assign bus.ovf     = ovf_q;
  assign bus.udf     = udf_q;

`ifdef SYNC_FIFO_PARITY_EN
  logic perr_s;
  if (FALLTHROUGH == "FALSE") begin : g_perr_reg
    // Decoded from the held read word, so it changes together with rdata.
    assign perr_s = parity_even(MAX_DATASIZE'(rword_s[DATASIZE-1:0])) ^ rword_s[DATASIZE];
  end else begin : g_perr_fwft
    assign perr_s = ~rempty_q &
                    (parity_even(MAX_DATASIZE'(rword_s[DATASIZE-1:0])) ^ rword_s[DATASIZE]);
  end
  assign bus.perr = perr_s;
`else
  assign bus.perr = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=4, AF_THR=3, AE_THR=1): one fall-through and one
// registered-read instance share identical stimulus.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       winc = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rinc = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  sync_fifo_if #(.DATASIZE(8), .ADDRSIZE(2)) bus_ft ();
  sync_fifo_if #(.DATASIZE(8), .ADDRSIZE(2)) bus_rg ();

  assign bus_ft.winc  = winc;
  assign bus_ft.wdata = wdata;
  assign bus_ft.rinc  = rinc;
  assign bus_rg.winc  = winc;
  assign bus_rg.wdata = wdata;
  assign bus_rg.rinc  = rinc;

  sync_fifo #(.DATASIZE(8), .ADDRSIZE(2), .FALLTHROUGH("TRUE"),
              .ALMOST_FULL_THR(3), .ALMOST_EMPTY_THR(1))
    dut_ft (.clk(clk), .arst(arst), .bus(bus_ft));

  sync_fifo #(.DATASIZE(8), .ADDRSIZE(2), .FALLTHROUGH("FALSE"),
              .ALMOST_FULL_THR(3), .ALMOST_EMPTY_THR(1))
    dut_rg (.clk(clk), .arst(arst), .bus(bus_rg));

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    logic [2:0] lvl;
    logic       ovf;
    logic       udf;
    logic       chk_ft;
    logic [7:0] ft;
    logic [7:0] rg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic w, input logic [7:0] d, input logic r, input logic [2:0] lvl,
                     input logic ovf, input logic udf, input logic chk_ft,
                     input logic [7:0] ft, input logic [7:0] rg);
    vec_t v;
    v.w = w; v.d = d; v.r = r; v.lvl = lvl; v.ovf = ovf; v.udf = udf;
    v.chk_ft = chk_ft; v.ft = ft; v.rg = rg;
    vecs.push_back(v);
  endtask

  // Flags expected from the occupancy: {wfull, awfull, rempty, arempty, ovf, udf}.
  task automatic check_state(input string tag, input logic [2:0] lvl,
                             input logic ovf, input logic udf);
    logic [5:0] exp;
    exp = {lvl == 3'd4, lvl >= 3'd3, lvl == 3'd0, lvl <= 3'd1, ovf, udf};
    check({tag, " ft level"}, 32'(bus_ft.level), 32'(lvl));
    check({tag, " rg level"}, 32'(bus_rg.level), 32'(lvl));
    check({tag, " ft flags"}, 32'({bus_ft.wfull, bus_ft.awfull, bus_ft.rempty,
                                   bus_ft.arempty, bus_ft.ovf, bus_ft.udf}), 32'(exp));
    check({tag, " rg flags"}, 32'({bus_rg.wfull, bus_rg.awfull, bus_rg.rempty,
                                   bus_rg.arempty, bus_rg.ovf, bus_rg.udf}), 32'(exp));
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r);
    @(negedge clk);
    winc = w; wdata = d; rinc = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    winc = 1'b0; rinc = 1'b0; arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
  endtask

  initial begin
    // Fill, overflow, drain, underflow.
    add(1'b1, 8'h11, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 8'h11, 8'h00);
    add(1'b1, 8'h22, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 8'h11, 8'h00);
    add(1'b1, 8'h33, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'h11, 8'h00);
    add(1'b1, 8'h44, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 8'h11, 8'h00);
    add(1'b1, 8'h55, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 8'h11, 8'h00);
    add(1'b0, 8'h00, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 8'h11, 8'h00);
    add(1'b0, 8'h00, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 8'h22, 8'h11);
    add(1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 8'h33, 8'h22);
    add(1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 8'h44, 8'h33);
    add(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h44);
    add(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h44);
    add(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h44);
    // Read while empty with a write: write lands, read is ignored.
    add(1'b1, 8'h66, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 8'h66, 8'h44);
    add(1'b1, 8'h77, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 8'h66, 8'h44);
    // Ten simultaneous push/pop cycles at level 2; pointers wrap twice.
    for (int i = 0; i < 10; i++) begin
      add(1'b1, 8'(8'h80 + i), 1'b1, 3'd2, 1'b0, 1'b0, 1'b1,
          (i == 0) ? 8'h77 : 8'(8'h7F + i),
          (i == 0) ? 8'h66 : ((i == 1) ? 8'h77 : 8'(8'h7E + i)));
    end
    add(1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 8'h89, 8'h88);
    add(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h89);
    // Full with write+read: read accepted, write dropped.
    add(1'b1, 8'hA0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 8'hA0, 8'h89);
    add(1'b1, 8'hA1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 8'hA0, 8'h89);
    add(1'b1, 8'hA2, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'hA0, 8'h89);
    add(1'b1, 8'hA3, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 8'hA0, 8'h89);
    add(1'b1, 8'hB0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 8'hA1, 8'hA0);
    add(1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 8'hA2, 8'hA1);
    add(1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 8'hA3, 8'hA2);
    add(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA3);

    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    #1;
    check_state("reset", 3'd0, 1'b0, 1'b0);
    check("reset rg rdata", 32'(bus_rg.rdata), 32'h00);
    check("reset ft perr", 32'(bus_ft.perr), 32'h0);
    check("reset rg perr", 32'(bus_rg.perr), 32'h0);

    foreach (vecs[k]) begin
      drive(vecs[k].w, vecs[k].d, vecs[k].r);
      check_state($sformatf("v%0d", k), vecs[k].lvl, vecs[k].ovf, vecs[k].udf);
      check($sformatf("v%0d rg rdata", k), 32'(bus_rg.rdata), 32'(vecs[k].rg));
      if (vecs[k].chk_ft) begin
        check($sformatf("v%0d ft rdata", k), 32'(bus_ft.rdata), 32'(vecs[k].ft));
      end
      check($sformatf("v%0d ft perr", k), 32'(bus_ft.perr), 32'h0);
      check($sformatf("v%0d rg perr", k), 32'(bus_rg.perr), 32'h0);
    end

    // Read latency: head visible while requested in FWFT, one edge later when registered.
    pulse_reset();
    #1;
    check("rst2 rg rdata", 32'(bus_rg.rdata), 32'h00);
    drive(1'b1, 8'hA5, 1'b0);
    @(negedge clk);
    winc = 1'b0; rinc = 1'b1;
    #1;
    check("lat ft rdata during rinc", 32'(bus_ft.rdata), 32'hA5);
    check("lat rg rdata before edge", 32'(bus_rg.rdata), 32'h00);
    @(posedge clk);
    #1;
    check("lat rg rdata after edge", 32'(bus_rg.rdata), 32'hA5);
    check_state("lat", 3'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a fill.
    drive(1'b1, 8'h3C, 1'b0);
    @(negedge clk);
    winc = 1'b1; wdata = 8'h5A;
    @(posedge clk);
    #2;
    arst = 1'b1;
    #1;
    check_state("midrst", 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    winc = 1'b0;
    arst = 1'b0;
    drive(1'b1, 8'hC3, 1'b0);
    check_state("post-rst write", 3'd1, 1'b0, 1'b0);
    check("post-rst ft head", 32'(bus_ft.rdata), 32'hC3);
    drive(1'b0, 8'h00, 1'b1);
    check("post-rst rg pop", 32'(bus_rg.rdata), 32'hC3);
    check_state("post-rst pop", 3'd0, 1'b0, 1'b0);

`ifdef SYNC_FIFO_PARITY_EN
    // Corrupt one stored bit of the first of two words (address 1 after the pops above).
    drive(1'b1, 8'h0F, 1'b0);
    drive(1'b1, 8'h12, 1'b0);
    @(negedge clk);
    winc = 1'b0;
    dut_ft.u_ram.mem_q[1] = dut_ft.u_ram.mem_q[1] ^ 9'h001;
    dut_rg.u_ram.mem_q[1] = dut_rg.u_ram.mem_q[1] ^ 9'h001;
    #1;
    check("par ft perr corrupt head", 32'(bus_ft.perr), 32'h1);
    drive(1'b0, 8'h00, 1'b1);
    check("par rg perr corrupt pop", 32'(bus_rg.perr), 32'h1);
    check("par ft perr clean head", 32'(bus_ft.perr), 32'h0);
    drive(1'b0, 8'h00, 1'b1);
    check("par rg perr clean pop", 32'(bus_rg.perr), 32'h0);
    check("par rg rdata clean pop", 32'(bus_rg.rdata), 32'h12);
`endif

    @(negedge clk);
    winc = 1'b0; rinc = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, word width in bits.
REQ-002 SHALL have parameter ADDRSIZE, default 4, address bits; DEPTH = 2**ADDRSIZE words.
REQ-003 SHALL have parameter FALLTHROUGH, default "TRUE", first-word fall-through ("TRUE") or registered read ("FALSE").
REQ-004 SHALL have parameter ALMOST_FULL_THR, default DEPTH-1, awfull threshold in words.
REQ-005 SHALL have parameter ALMOST_EMPTY_THR, default 1, arempty threshold in words.
REQ-006 SHALL have port clk, input, 1, single clock for all logic, rising edge.
REQ-007 SHALL have port arst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have ports winc (input, 1, write request) and wdata (input, DATASIZE, write word).
REQ-009 SHALL have ports rinc (input, 1, read request/pop) and rdata (output, DATASIZE, read word).
REQ-010 SHALL have outputs wfull, awfull, rempty and arempty, each 1 bit, all registered.
REQ-011 SHALL have output level, ADDRSIZE+1 bits, registered word count 0..DEPTH.
REQ-012 SHALL have outputs ovf and udf, each 1 bit, registered one-cycle error pulses.
REQ-013 SHALL have output perr, 1 bit, read parity error.

Function
REQ-014 Write accepted iff winc && !wfull: word stored at wptr, wptr increments at the edge.
REQ-015 Read accepted iff rinc && !rempty: rptr increments at the edge.
REQ-016 Pointers SHALL be ADDRSIZE+1-bit binary and wrap modulo 2*DEPTH; the low ADDRSIZE bits address memory.
REQ-017 level SHALL be +1 on write only, -1 on read only, and unchanged on both or neither.
REQ-018 Flags SHALL be computed from the next level: wfull = (level==DEPTH), rempty = (level==0), awfull = (level>=ALMOST_FULL_THR), arempty = (level<=ALMOST_EMPTY_THR).
REQ-019 A write while full SHALL be dropped: memory and pointers unchanged, ovf pulses high for 1 cycle; the same applies when rinc is simultaneously high.
REQ-020 A read while empty SHALL be ignored: udf pulses high for 1 cycle; a simultaneous write is still accepted.
REQ-021 With FALLTHROUGH="TRUE", rdata SHALL combinationally equal mem[rptr]; it is valid whenever rempty=0, with zero-latency head visibility.
REQ-022 With FALLTHROUGH="FALSE", rdata SHALL load the popped word at the edge of an accepted read (1-cycle latency) and hold otherwise.
REQ-023 A simultaneous read and write SHALL return the old head when the FIFO is non-empty; read-during-write to the same address cannot occur.

Reset
REQ-024 arst SHALL asynchronously clear wptr, rptr, level, wfull, awfull, ovf, udf and perr to 0, and set rempty and arempty to 1.
REQ-025 In registered mode, rdata SHALL reset to 0; memory contents SHALL NOT be reset.
REQ-026 Reset asserted mid-transfer SHALL discard all stored words; the first write after release lands at address 0.

Configuration
REQ-027 Macro SYNC_FIFO_PARITY_EN defined: memory SHALL be DATASIZE+1 bits wide and store even parity of wdata.
REQ-028 With the macro, perr SHALL flag a parity mismatch on the read word: combinational with rdata in FWFT mode (qualified by !rempty), registered alongside rdata in registered mode.
REQ-029 Macro undefined: memory SHALL be DATASIZE bits wide and perr SHALL be tied 0.

Structure
REQ-030 A shared package sync_fifo_pkg SHALL hold the parity function and the flag-threshold checking constants.
REQ-031 Storage SHALL be one sub-module sync_fifo_ram: one write port, one read port, FALLTHROUGH parameter; the control logic stays in sync_fifo.
REQ-032 Elaboration SHALL fail if ALMOST_FULL_THR > DEPTH or ALMOST_EMPTY_THR >= DEPTH.

Verification (DATASIZE=8, ADDRSIZE=2, DEPTH=4, AF_THR=3, AE_THR=1)
REQ-033 Reset, then 4 writes 0x11..0x44 -> level 1,2,3,4; awfull asserts at level 3; wfull at level 4; arempty deasserts at level 2.
REQ-034 Full, winc with 0x55 -> ovf 1 cycle; level stays 4; subsequent reads return 0x11,0x22,0x33,0x44, then rempty=1.
REQ-035 Empty, rinc -> udf 1 cycle; level 0; rdata unchanged in registered mode.
REQ-036 Level 2, winc+rinc for 10 cycles with incrementing data -> level stays 2, data in order, pointers wrap twice with no loss.
REQ-037 FALLTHROUGH="FALSE", write 0xA5 then rinc -> rdata=0xA5 one edge after the accepted read; with FALLTHROUGH="TRUE", 0xA5 is visible while the read is requested.
REQ-038 SYNC_FIFO_PARITY_EN, force a flipped bit in the stored word -> perr=1 on that read; clean words give perr=0; arst mid-fill -> rempty=1, level=0.
